// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel output framing stage.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } sobel_sb_t;

  typedef enum logic {
    SYNC,
    RUN
  } framer_state_t;

  // Unsigned threshold of one channel; equality counts as "above".
  function automatic logic [PIX_W-1:0] binarize_ch(input logic [PIX_W-1:0] ch,
                                                   input logic [PIX_W-1:0] thresh);
    return (ch >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  endfunction

endpackage

// File: rtl/sobel_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is only
// legal together with a pop; the caller guarantees that.
module sobel_fifo #(
  parameter int WIDTH_P = 11,
  parameter int DEPTH_P = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push,
  input  logic [WIDTH_P-1:0]         wr_data,
  input  logic                       pop,
  output logic [WIDTH_P-1:0]         rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH_P):0]   count
);

  localparam int AW = $clog2(DEPTH_P);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [WIDTH_P-1:0] mem [DEPTH_P];

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sobel_output_framer.sv
// Frames the free-running sobel pixel stream: optional binarization,
// sof/eol/eof tagging, and a FIFO onto a ready/valid sink with drop
// accounting.
//
// state | meaning
// ------+-----------------------------------------------------------
// SYNC  | after reset or a drop; waiting to capture pixel (0,0)
// RUN   | frame aligned, no drop since the last (0,0)
//
// The capture register doubles as a one-entry holding slot: when the
// FIFO cannot take it, it waits. It is only lost (counted as a drop)
// when a new pixel arrives and must overwrite it, so the newest pixel
// always survives and position tracking never depends on drops.
module sobel_output_framer
  import sobel_pkg::*;
#(
  parameter int WIDTH_P    = 8,
  parameter int HEIGHT_P   = 8,
  parameter int CHANNELS_P = 1,
  parameter int DEPTH_P    = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        valid_i,
  input  logic [CHANNELS_P*PIX_W-1:0] pixel_i,
  input  logic                        binarize_i,
  input  logic [PIX_W-1:0]            thresh_i,
  input  logic                        clear_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [CHANNELS_P*PIX_W-1:0] pixel_o,
  output logic                        sof_o,
  output logic                        eol_o,
  output logic                        eof_o,
  output logic                        overflow_o,
  output logic [15:0]                 drop_count_o
);

  localparam int PW = CHANNELS_P * PIX_W;
  localparam int EW = PW + $bits(sobel_sb_t);
  localparam int XW = $clog2(WIDTH_P);
  localparam int YW = $clog2(HEIGHT_P);
  localparam int AW = $clog2(DEPTH_P);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH_P - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_P - 1);

  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           pos_first;
  logic           pos_eol;
  logic           pos_eof;

  logic [PW-1:0]  cap_pix_d;
  logic           cap_vld;
  logic [PW-1:0]  cap_pix;
  sobel_sb_t      cap_sb;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           can_write;
  logic           drop;
  logic [EW-1:0]  fifo_rd_data;
  logic [AW:0]    fifo_count;
  logic           unused_fifo_count;

  logic [PW-1:0]  head_pix;
  sobel_sb_t      head_sb;

  framer_state_t  state_q;
  framer_state_t  state_d;

  assign pos_first = (x_q == '0) && (y_q == '0);
  assign pos_eol   = (x_q == X_LAST);
  assign pos_eof   = pos_eol && (y_q == Y_LAST);

  // Raster position of the pixel arriving this cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (valid_i) begin
      if (pos_eol) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Per-channel binarization of the incoming pixel.
  always_comb begin
    cap_pix_d = '0;
    for (int c = 0; c < CHANNELS_P; c++) begin
      cap_pix_d[c*PIX_W +: PIX_W] = binarize_i
        ? binarize_ch(pixel_i[c*PIX_W +: PIX_W], thresh_i)
        : pixel_i[c*PIX_W +: PIX_W];
    end
  end

  assign fifo_pop  = !fifo_empty && ready_i;
  assign can_write = !fifo_full || fifo_pop;
  assign fifo_push = cap_vld && can_write;
  assign drop      = cap_vld && !can_write && valid_i;

  // Capture/holding register: loads every new pixel, empties once written.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cap_vld <= 1'b0;
      cap_pix <= '0;
      cap_sb  <= '0;
    end else if (valid_i) begin
      cap_vld    <= 1'b1;
      cap_pix    <= cap_pix_d;
      cap_sb.sof <= pos_first;
      cap_sb.eol <= pos_eol;
      cap_sb.eof <= pos_eof;
    end else if (fifo_push) begin
      cap_vld <= 1'b0;
    end
  end

  sobel_fifo #(
    .WIDTH_P (EW),
    .DEPTH_P (DEPTH_P)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push      (fifo_push),
    .wr_data   ({cap_pix, cap_sb}),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  // Sticky overflow flag and saturating drop counter; a drop beats clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (drop) begin
      overflow_o   <= 1'b1;
      if (clear_i)
        drop_count_o <= 16'd1;
      else if (drop_count_o != 16'hFFFF)
        drop_count_o <= drop_count_o + 16'd1;
    end else if (clear_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end
  end

  // Frame-sync state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= SYNC;
    else            state_q <= state_d;
  end

  // Capturing (0,0) re-aligns even if the slot it replaces was dropped,
  // since the kept pixel is the new frame start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (valid_i && pos_first) state_d = RUN;
      RUN:     if (valid_i && pos_first) state_d = RUN;
               else if (drop)            state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  assign {head_pix, head_sb} = fifo_rd_data;

  // Head entry presentation; outputs forced to zero while empty.
  always_comb begin
    valid_o = !fifo_empty;
    pixel_o = '0;
    sof_o   = 1'b0;
    eol_o   = 1'b0;
    eof_o   = 1'b0;
    if (!fifo_empty) begin
      pixel_o = head_pix;
      sof_o   = head_sb.sof;
      eol_o   = head_sb.eol;
      eof_o   = head_sb.eof;
    end
  end

endmodule

// File: tb/tb_sobel_output_framer.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_sobel_output_framer;

  localparam int W = 8;
  localparam int H = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] pix;
    bit         sof;
    bit         eol;
    bit         eof;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        valid_i;
  logic [7:0]  pixel_i;
  logic        binarize_i;
  logic [7:0]  thresh_i;
  logic        clear_i;
  logic        ready_i;
  logic        valid_o;
  logic [7:0]  pixel_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;
  logic        overflow_o;
  logic [15:0] drop_count_o;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  ent_t m_q[$];
  ent_t m_hold;
  bit   m_hold_v;
  int   mx, my;
  bit   m_ovf;
  int   m_drops;

  ent_t out_q[$];
  logic obs_valid;

  sobel_output_framer #(
    .WIDTH_P    (W),
    .HEIGHT_P   (H),
    .CHANNELS_P (1),
    .DEPTH_P    (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .valid_i      (valid_i),
    .pixel_i      (pixel_i),
    .binarize_i   (binarize_i),
    .thresh_i     (thresh_i),
    .clear_i      (clear_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .pixel_o      (pixel_o),
    .sof_o        (sof_o),
    .eol_o        (eol_o),
    .eof_o        (eof_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hold_v = 0;
    mx = 0;
    my = 0;
    m_ovf = 0;
    m_drops = 0;
  endtask

  // One clock edge of the framer, described at stream level.
  task automatic model_edge(input bit v, input logic [7:0] pix, input bit bin,
                            input logic [7:0] thr, input bit clr, input bit rdy);
    bit drop;
    drop = 0;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (m_hold_v) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_hold);
        m_hold_v = 0;
      end else if (v) begin
        drop = 1;
      end
    end
    if (v) begin
      m_hold.pix = bin ? ((pix >= thr) ? 8'hFF : 8'h00) : pix;
      m_hold.sof = (mx == 0 && my == 0);
      m_hold.eol = (mx == W - 1);
      m_hold.eof = (mx == W - 1) && (my == H - 1);
      m_hold_v = 1;
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my + 1) % H;
      end
    end
    if (drop) begin
      m_ovf = 1;
      m_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
    end else if (clr) begin
      m_ovf = 0;
      m_drops = 0;
    end
  endtask

  task automatic compare_outputs();
    obs_valid = valid_o;
    chk("valid_o", valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("pixel_o", pixel_o, m_q[0].pix);
      chk("sof_o", sof_o, m_q[0].sof);
      chk("eol_o", eol_o, m_q[0].eol);
      chk("eof_o", eof_o, m_q[0].eof);
    end
    chk("overflow_o", overflow_o, m_ovf);
    chk("drop_count_o", drop_count_o, m_drops);
  endtask

  task automatic step(input bit v, input logic [7:0] pix, input bit bin,
                      input logic [7:0] thr, input bit clr, input bit rdy);
    ent_t e;
    @(negedge clk_i);
    valid_i = v; pixel_i = pix; binarize_i = bin;
    thresh_i = thr; clear_i = clr; ready_i = rdy;
    #1;
    compare_outputs();
    if (valid_o && rdy) begin
      e.pix = pixel_o; e.sof = sof_o; e.eol = eol_o; e.eof = eof_o;
      out_q.push_back(e);
    end
    model_edge(v, pix, bin, thr, clr, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0, rdy);
  endtask

  task automatic do_reset();
    reset_n_i = 0;
    valid_i = 0; pixel_i = 0; binarize_i = 0; thresh_i = 0; clear_i = 0; ready_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_pixel_o", pixel_o, 0);
    chk("rst_sb", {sof_o, eol_o, eof_o}, 0);
    chk("rst_overflow_o", overflow_o, 0);
    chk("rst_drop_count_o", drop_count_o, 0);
    reset_n_i = 1;
  endtask

  initial begin
    logic [7:0] tv [5];
    logic [7:0] tb_exp [5];
    int nsof, neof, pidx;
    logic [7:0] sof_pix, eof_pix;

    tv     = '{8'd99, 8'd100, 8'd101, 8'd0, 8'd255};
    tb_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};

    do_reset();

    // 1: one full frame, pixel = index, sink always ready
    out_q.delete();
    for (int i = 0; i < W * H; i++) begin
      step(1, 8'(i), 0, 8'h00, 0, 1);
      if (i == 1) chk("lat_n1", obs_valid, 0);
      if (i == 2) chk("lat_n2", obs_valid, 1);
    end
    idle(4, 1);
    chk("t1_count", out_q.size(), W * H);
    for (int i = 0; i < out_q.size(); i++) begin
      chk("t1_pix", out_q[i].pix, 8'(i));
      chk("t1_sof", out_q[i].sof, i == 0);
      chk("t1_eol", out_q[i].eol, (i % W) == W - 1);
      chk("t1_eof", out_q[i].eof, i == W * H - 1);
    end

    // 2: binarization around threshold 100, then pass-through
    out_q.delete();
    for (int i = 0; i < 5; i++) step(1, tv[i], 1, 8'd100, 0, 1);
    idle(4, 1);
    chk("t2_bin_count", out_q.size(), 5);
    for (int i = 0; i < 5 && i < out_q.size(); i++) chk("t2_bin_pix", out_q[i].pix, tb_exp[i]);
    out_q.delete();
    for (int i = 0; i < 5; i++) step(1, tv[i], 0, 8'd100, 0, 1);
    idle(4, 1);
    chk("t2_pass_count", out_q.size(), 5);
    for (int i = 0; i < 5 && i < out_q.size(); i++) chk("t2_pass_pix", out_q[i].pix, tv[i]);

    // 3: stalled sink overflows, frame alignment survives
    pidx = my * W + mx;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(pidx), 0, 8'h00, 0, 0);
      pidx++;
    end
    idle(1, 0);
    chk("t3_drops", drop_count_o, 3);
    chk("t3_overflow", overflow_o, 1);
    out_q.delete();
    while (pidx < W * H + 10) begin
      step(1, 8'(pidx), 0, 8'h00, 0, 1);
      pidx++;
    end
    idle(20, 1);
    nsof = 0; neof = 0; sof_pix = 0; eof_pix = 0;
    foreach (out_q[i]) begin
      if (out_q[i].sof) begin nsof++; sof_pix = out_q[i].pix; end
      if (out_q[i].eof) begin neof++; eof_pix = out_q[i].pix; end
    end
    chk("t3_out_count", out_q.size(), 61);
    chk("t3_nsof", nsof, 1);
    chk("t3_sof_pix", sof_pix, 8'(W * H));
    chk("t3_neof", neof, 1);
    chk("t3_eof_pix", eof_pix, 8'(W * H - 1));

    // 5a: clear with no drop
    step(0, 8'h00, 0, 8'h00, 1, 1);
    idle(1, 1);
    chk("t5_clr_ovf", overflow_o, 0);
    chk("t5_clr_cnt", drop_count_o, 0);

    // 4: full FIFO with a streaming sink never drops
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'($urandom), 0, 8'h00, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 0, 8'h00, 0, 1);
    idle(1, 1);
    chk("t4_drops", drop_count_o, 0);
    chk("t4_overflow", overflow_o, 0);
    idle(20, 1);

    // 5b: clear coincident with a drop
    for (int i = 0; i < DEPTH + 3; i++) step(1, 8'($urandom), 0, 8'h00, 0, 0);
    step(1, 8'($urandom), 0, 8'h00, 1, 0);
    idle(1, 0);
    chk("t5_drop_clr_ovf", overflow_o, 1);
    chk("t5_drop_clr_cnt", drop_count_o, 1);
    idle(20, 1);

    // 6: reset in the middle of a frame at (3,2)
    do_reset();
    for (int i = 0; i < 2 * W + 3; i++) step(1, 8'($urandom), 0, 8'h00, 0, 0);
    #2;
    chk("t6_pre_valid", valid_o, 1);
    reset_n_i = 0;
    #1;
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_pixel", pixel_o, 0);
    model_reset();
    @(negedge clk_i);
    valid_i = 0; clear_i = 0; ready_i = 0;
    reset_n_i = 1;
    out_q.delete();
    for (int i = 0; i < W; i++) step(1, 8'(8'hA0 + i), 0, 8'h00, 0, 1);
    idle(4, 1);
    chk("t6_count", out_q.size(), W);
    foreach (out_q[i]) begin
      chk("t6_pix", out_q[i].pix, 8'(8'hA0 + i));
      chk("t6_sof", out_q[i].sof, i == 0);
    end

    // random traffic against the model
    for (int ep = 0; ep < 6; ep++) begin
      int rdy_pct;
      rdy_pct = (ep % 3 == 0) ? 20 : ((ep % 3 == 1) ? 60 : 95);
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
             8'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 99) < rdy_pct);
      end
    end
    idle(24, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
